// File: rtl/cmd_packet_arbiter.sv
// cmd_packet_arbiter
// Packet-atomic arbiter that shares the parser's command byte input between
// the host UART byte stream (buffered in a FIFO, no backpressure) and a local
// on-chip sequencer (valid/ready). DATA, FREQ and PERIOD packets reach the
// parser whole and never interleave.
//
// Build option: define CMD_ARB_HOST_PRIORITY_EN for fixed host priority when
// both sources are eligible; otherwise arbitration is round-robin.
//
// Local handshake: a local byte transfers in a cycle where
// loc_valid_i & loc_ready_o. loc_ready_o is combinational from state, owner
// and loc_valid_i. The sequencer may drop loc_valid_i mid-packet (stall);
// the arbiter then waits without a timeout.
module cmd_packet_arbiter #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         GAP_CYCLES = 1,
  parameter logic [7:0] CMD_DATA   = 8'h01,
  parameter logic [7:0] CMD_FREQ   = 8'h02,
  parameter logic [7:0] CMD_PERIOD = 8'h03
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] host_data_i,
  input  logic       host_tick_i,
  input  logic [7:0] loc_data_i,
  input  logic       loc_valid_i,
  output logic       loc_ready_o,
  output logic [7:0] data_o,
  output logic       rx_done_tick_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       err_tick_o,
  output logic       ovf_o,
  output logic [1:0] state_o
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          CW       = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]  GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e      state, state_d;
  logic [2:0]  rem, rem_d;
  logic [3:0]  gap_cnt, gap_d;
  logic [1:0]  grant_d;
  logic        busy_d;
  logic [7:0]  data_d;
  logic        tick_d;
  logic        err_d;
  logic        owner_has;

  // host FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        empty, full;
  logic        pop, wr_en;
  logic [7:0]  head;

  // arbitration
  logic [2:0]  host_len, loc_len;
  logic        host_inv, host_elig;
  logic        loc_inv, loc_elig;
  logic        pick_host, pick_loc;

  // Packet length from a command byte; 0 marks an unknown command.
  function automatic logic [2:0] pkt_len(input logic [7:0] b);
    if (b == CMD_DATA)        return 3'd6;
    else if (b == CMD_FREQ)   return 3'd5;
    else if (b == CMD_PERIOD) return 3'd3;
    else                      return 3'd0;
  endfunction

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = mem[rd_ptr[AW-1:0]];
  // A pop in the same cycle frees the slot, so a write on a full FIFO is
  // still accepted then.
  assign wr_en = host_tick_i & (~full | pop);

  assign host_len  = pkt_len(head);
  assign loc_len   = pkt_len(loc_data_i);
  assign host_inv  = ~empty & (host_len == 3'd0);
  assign host_elig = ~empty & (host_len != 3'd0) &
                     (count >= {{(AW-2){1'b0}}, host_len});
  assign loc_inv   = loc_valid_i & (loc_len == 3'd0);
  assign loc_elig  = loc_valid_i & (loc_len != 3'd0);
  assign pick_host = host_elig & ~pick_loc;

`ifdef CMD_ARB_HOST_PRIORITY_EN
  assign pick_loc = loc_elig & ~host_elig;
`else
  logic prefer_loc, prefer_loc_d;

  assign pick_loc = loc_elig & (~host_elig | prefer_loc);

  // Round-robin pointer: after any grant, favour the other source next time.
  always_comb begin
    prefer_loc_d = prefer_loc;
    if (state == ST_IDLE) begin
      if (pick_host)     prefer_loc_d = 1'b1;
      else if (pick_loc) prefer_loc_d = 1'b0;
    end
  end

  // Pointer register; host is favoured out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prefer_loc <= 1'b0;
    else         prefer_loc <= prefer_loc_d;
  end
`endif

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= host_data_i;
  end

  // FIFO pointers and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (host_tick_i & full & ~pop) ovf_o <= 1'b1;
    end
  end

  // Next-state and output decode: grant in IDLE, one byte per SEND, pacing in GAP.
  always_comb begin
    state_d     = state;
    rem_d       = rem;
    gap_d       = gap_cnt;
    grant_d     = grant_o;
    busy_d      = busy_o;
    data_d      = data_o;
    tick_d      = 1'b0;
    err_d       = 1'b0;
    pop         = 1'b0;
    loc_ready_o = 1'b0;
    owner_has   = grant_o[0] ? ~empty : loc_valid_i;
    case (state)
      ST_IDLE: begin
        if (pick_host) begin
          grant_d = 2'b01;
          rem_d   = host_len;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end else if (pick_loc) begin
          grant_d = 2'b10;
          rem_d   = loc_len;
          busy_d  = 1'b1;
          state_d = ST_SEND;
        end else begin
          // Unknown command bytes are dropped only when nobody is granted.
          pop         = host_inv;
          loc_ready_o = loc_inv;
          err_d       = host_inv | loc_inv;
        end
      end
      ST_SEND: begin
        if (owner_has) begin
          data_d      = grant_o[0] ? head : loc_data_i;
          tick_d      = 1'b1;
          pop         = grant_o[0];
          loc_ready_o = grant_o[1];
          rem_d       = rem - 3'd1;
          if (GAP_CYCLES != 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else if (rem == 3'd1) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            busy_d  = 1'b0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          if (rem != 3'd0) begin
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_cnt - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      rem            <= 3'd0;
      gap_cnt        <= 4'd0;
      grant_o        <= 2'b00;
      busy_o         <= 1'b0;
      data_o         <= 8'h00;
      rx_done_tick_o <= 1'b0;
      err_tick_o     <= 1'b0;
    end else begin
      state          <= state_d;
      rem            <= rem_d;
      gap_cnt        <= gap_d;
      grant_o        <= grant_d;
      busy_o         <= busy_d;
      data_o         <= data_d;
      rx_done_tick_o <= tick_d;
      err_tick_o     <= err_d;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cmd_packet_arbiter.sv
// Testbench for cmd_packet_arbiter (FIFO_DEPTH=8, GAP_CYCLES=1, round-robin).
module tb_cmd_packet_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] host_data_i = 8'h00;
  logic       host_tick_i = 1'b0;
  logic [7:0] loc_data_i = 8'h00;
  logic       loc_valid_i = 1'b0;
  logic       loc_ready_o;
  logic [7:0] data_o;
  logic       rx_done_tick_o;
  logic [1:0] grant_o;
  logic       busy_o;
  logic       err_tick_o;
  logic       ovf_o;
  logic [1:0] state_o;

  cmd_packet_arbiter #(
    .FIFO_DEPTH(8),
    .GAP_CYCLES(1)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .host_data_i    (host_data_i),
    .host_tick_i    (host_tick_i),
    .loc_data_i     (loc_data_i),
    .loc_valid_i    (loc_valid_i),
    .loc_ready_o    (loc_ready_o),
    .data_o         (data_o),
    .rx_done_tick_o (rx_done_tick_o),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .err_tick_o     (err_tick_o),
    .ovf_o          (ovf_o),
    .state_o        (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [1:0] exp_g_q[$];
  logic [7:0] got_q[$];
  logic [1:0] got_g_q[$];
  int         got_c_q[$];
  int         err_cnt = 0;
  int         compared = 0;
  int         mismatched = 0;
  int         last_wr_edge = 0;
  int         loc_edge = 0;

  // Output monitor: log every parser tick with its owner and edge number.
  always begin
    @(posedge clk_i);
    #1;
    if (rx_done_tick_o) begin
      got_q.push_back(data_o);
      got_g_q.push_back(grant_o);
      got_c_q.push_back(cyc);
    end
    if (err_tick_o) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    got_g_q.delete();
    got_c_q.delete();
    exp_q.delete();
    exp_g_q.delete();
    err_cnt = 0;
  endtask

  // Push n expected bytes, first byte in the top byte of b.
  task automatic exp_pkt(input logic [47:0] b, input int n, input logic [1:0] g);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(b[47-8*i -: 8]);
      exp_g_q.push_back(g);
    end
  endtask

  task automatic compare_log(input string name);
    check({name, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s byte%0d", name, i), got_q[i], exp_q[i]);
      check($sformatf("%s grant%0d", name, i), got_g_q[i], exp_g_q[i]);
    end
  endtask

  // Wait (bounded) for n logged output bytes, then let the block settle.
  task automatic wait_out(input int n, input string name);
    for (int k = 0; k < 300 && got_q.size() < n; k++) @(negedge clk_i);
    if (got_q.size() < n) begin
      compared++;
      mismatched++;
      $display("FAIL %s timeout: got %0d bytes, expected %0d", name, got_q.size(), n);
    end
    repeat (8) @(negedge clk_i);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // Called at a negedge; presents one host byte for one cycle.
  task automatic host_byte(input logic [7:0] b);
    host_data_i  = b;
    host_tick_i  = 1'b1;
    last_wr_edge = cyc + 1;
    @(negedge clk_i);
    host_tick_i = 1'b0;
  endtask

  // Called at a negedge; holds a local byte valid until accepted (bounded).
  task automatic loc_send(input logic [7:0] b);
    bit done;
    done        = 1'b0;
    loc_data_i  = b;
    loc_valid_i = 1'b1;
    loc_edge    = cyc + 1;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      done = loc_ready_o;
      @(negedge clk_i);
    end
    loc_valid_i = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL loc_handshake timeout: byte %0h never accepted", b);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_loc;
    int          n_in;
    logic [55:0] in_b;   // first byte in the top byte
    int          n_out;
    logic [47:0] out_b;  // first byte in the top byte
    int          n_err;
    logic [1:0]  grant;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 5, {8'h02, 8'h55, 8'h55, 8'h55, 8'h55, 16'h0}, 5, {8'h02, 8'h55, 8'h55, 8'h55, 8'h55, 8'h00}, 0, 2'b01};
    vecs[1] = '{1'b0, 6, {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h00}, 6, {8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5}, 0, 2'b01};
    vecs[2] = '{1'b0, 3, {8'h03, 8'h14, 8'h05, 32'h0}, 3, {8'h03, 8'h14, 8'h05, 24'h0}, 0, 2'b01};
    vecs[3] = '{1'b1, 3, {8'h03, 8'h0A, 8'h0B, 32'h0}, 3, {8'h03, 8'h0A, 8'h0B, 24'h0}, 0, 2'b10};
    vecs[4] = '{1'b1, 5, {8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 16'h0}, 5, {8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}, 0, 2'b10};
    vecs[5] = '{1'b0, 4, {8'h7F, 8'h03, 8'h14, 8'h05, 24'h0}, 3, {8'h03, 8'h14, 8'h05, 24'h0}, 1, 2'b01};
    vecs[6] = '{1'b1, 4, {8'h00, 8'h03, 8'h66, 8'h77, 24'h0}, 3, {8'h03, 8'h66, 8'h77, 24'h0}, 1, 2'b10};
    vecs[7] = '{1'b1, 6, {8'h01, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'h00}, 6, {8'h01, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5}, 0, 2'b10};
    vecs[8] = '{1'b0, 1, {8'h04, 48'h0}, 0, 48'h0, 1, 2'b01};

    // ---- reset state ----
    repeat (3) @(negedge clk_i);
    check("rst data_o", data_o, 8'h00);
    check("rst rx_done_tick_o", rx_done_tick_o, 1'b0);
    check("rst grant_o", grant_o, 2'b00);
    check("rst busy_o", busy_o, 1'b0);
    check("rst err_tick_o", err_tick_o, 1'b0);
    check("rst ovf_o", ovf_o, 1'b0);
    check("rst loc_ready_o", loc_ready_o, 1'b0);
    check("rst state", state_o, 2'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // ---- host FREQ latency and byte spacing ----
    clear_log();
    host_byte(8'h02); host_byte(8'h55); host_byte(8'h55); host_byte(8'h55); host_byte(8'h55);
    exp_pkt({8'h02, 8'h55, 8'h55, 8'h55, 8'h55, 8'h00}, 5, 2'b01);
    wait_out(5, "host_freq");
    compare_log("host_freq");
    if (got_c_q.size() >= 5) begin
      check("host first tick latency", got_c_q[0] - last_wr_edge, 2);
      for (int i = 1; i < 5; i++)
        check($sformatf("host tick spacing%0d", i), got_c_q[i] - got_c_q[i-1], 2);
    end
    check("host_freq busy after", busy_o, 1'b0);
    check("host_freq grant after", grant_o, 2'b00);

    // ---- local latency ----
    clear_log();
    loc_send(8'h03);
    check("loc first tick latency", (got_c_q.size() > 0) ? got_c_q[0] - loc_edge : -1, 1);
    loc_send(8'h0A); loc_send(8'h0B);
    exp_pkt({8'h03, 8'h0A, 8'h0B, 24'h0}, 3, 2'b10);
    wait_out(3, "loc_period");
    compare_log("loc_period");

    // ---- table-driven single-source packets ----
    for (int v = 0; v < 9; v++) begin
      clear_log();
      for (int j = 0; j < vecs[v].n_in; j++) begin
        if (vecs[v].is_loc) loc_send(vecs[v].in_b[55-8*j -: 8]);
        else                host_byte(vecs[v].in_b[55-8*j -: 8]);
      end
      exp_pkt(vecs[v].out_b, vecs[v].n_out, vecs[v].grant);
      wait_out(vecs[v].n_out, $sformatf("vec%0d", v));
      compare_log($sformatf("vec%0d", v));
      check($sformatf("vec%0d err count", v), err_cnt, vecs[v].n_err);
    end

    // ---- contention: host wins first collision, round-robin then favours local ----
    do_reset();
    clear_log();
    host_byte(8'h01); host_byte(8'h55); host_byte(8'h55);
    host_byte(8'h55); host_byte(8'h55); host_byte(8'h28);
    loc_send(8'h03); loc_send(8'h14); loc_send(8'h05);
    exp_pkt({8'h01, 8'h55, 8'h55, 8'h55, 8'h55, 8'h28}, 6, 2'b01);
    exp_pkt({8'h03, 8'h14, 8'h05, 24'h0}, 3, 2'b10);
    wait_out(9, "collide1");
    compare_log("collide1");
    if (got_c_q.size() >= 7)
      check("packet spacing", got_c_q[6] - got_c_q[5], 3);

    clear_log();
    host_byte(8'h03); host_byte(8'h51); host_byte(8'h52);
    exp_pkt({8'h03, 8'h51, 8'h52, 24'h0}, 3, 2'b01);
    wait_out(3, "host_between");
    compare_log("host_between");

    clear_log();
    host_byte(8'h03); host_byte(8'h21); host_byte(8'h22);
    loc_send(8'h03); loc_send(8'h31); loc_send(8'h32);
    exp_pkt({8'h03, 8'h31, 8'h32, 24'h0}, 3, 2'b10);
    exp_pkt({8'h03, 8'h21, 8'h22, 24'h0}, 3, 2'b01);
    wait_out(6, "collide2");
    compare_log("collide2");

    // ---- local stall with host bytes arriving ----
    do_reset();
    clear_log();
    loc_send(8'h01);
    host_byte(8'h03); host_byte(8'h14); host_byte(8'h05);
    repeat (17) @(negedge clk_i);
    check("stall bytes out", got_q.size(), 1);
    check("stall busy", busy_o, 1'b1);
    check("stall grant", grant_o, 2'b10);
    loc_send(8'hA1); loc_send(8'hA2); loc_send(8'hA3); loc_send(8'hA4); loc_send(8'hA5);
    exp_pkt({8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5}, 6, 2'b10);
    exp_pkt({8'h03, 8'h14, 8'h05, 24'h0}, 3, 2'b01);
    wait_out(9, "stall");
    compare_log("stall");
    check("stall err count", err_cnt, 0);

    // ---- overflow while local owns a stalled packet ----
    do_reset();
    clear_log();
    loc_send(8'h01);
    host_byte(8'h03); host_byte(8'h41); host_byte(8'h42); host_byte(8'h03);
    host_byte(8'h43); host_byte(8'h44); host_byte(8'h03); host_byte(8'h45);
    check("ovf after 8 bytes", ovf_o, 1'b0);
    host_byte(8'h46);
    check("ovf after 9th byte", ovf_o, 1'b1);
    loc_send(8'hD1); loc_send(8'hD2); loc_send(8'hD3); loc_send(8'hD4); loc_send(8'hD5);
    exp_pkt({8'h01, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5}, 6, 2'b10);
    exp_pkt({8'h03, 8'h41, 8'h42, 24'h0}, 3, 2'b01);
    exp_pkt({8'h03, 8'h43, 8'h44, 24'h0}, 3, 2'b01);
    wait_out(12, "overflow");
    compare_log("overflow");
    check("ovf sticky", ovf_o, 1'b1);

    // ---- reset during the 3rd byte of a host DATA packet ----
    do_reset();
    check("ovf cleared by reset", ovf_o, 1'b0);
    clear_log();
    host_byte(8'h01); host_byte(8'h11); host_byte(8'h22);
    host_byte(8'h33); host_byte(8'h44); host_byte(8'h55);
    for (int k = 0; k < 100 && got_q.size() < 3; k++) @(negedge clk_i);
    check("midrst reached 3rd byte", got_q.size(), 3);
    rst_ni = 1'b0;
    #1;
    check("midrst data_o", data_o, 8'h00);
    check("midrst rx_done_tick_o", rx_done_tick_o, 1'b0);
    check("midrst grant_o", grant_o, 2'b00);
    check("midrst busy_o", busy_o, 1'b0);
    check("midrst err_tick_o", err_tick_o, 1'b0);
    check("midrst ovf_o", ovf_o, 1'b0);
    check("midrst loc_ready_o", loc_ready_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    clear_log();
    host_byte(8'h03); host_byte(8'h14); host_byte(8'h05);
    exp_pkt({8'h03, 8'h14, 8'h05, 24'h0}, 3, 2'b01);
    wait_out(3, "after_rst");
    compare_log("after_rst");
    check("after_rst err count", err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cmd_packet_arbiter.md
# cmd_packet_arbiter

Packet-atomic arbiter that shares the `diff_freq_serial_out` command byte input between two sources: the host (UART rx byte stream) and a local on-chip sequencer. It sits between `UART` and `diff_freq_serial_out`, replacing the direct `rx_data_o`/`rx_done_tick_o` connection. Command packets (DATA, FREQ, PERIOD) always reach the parser whole and never interleave. Host bytes are buffered in an internal FIFO because the UART has no backpressure.

## Interface
- `FIFO_DEPTH`, 8: host FIFO entries. Power of two, ≥ 6.
- `GAP_CYCLES`, 1: minimum idle cycles after every output tick (0..15).
- `CMD_DATA`, 8'h01: DATA command code. Packet is 6 bytes: cmd, 4 pattern, control.
- `CMD_FREQ`, 8'h02: FREQ command code. Packet is 5 bytes: cmd, 4 pattern, LSB first.
- `CMD_PERIOD`, 8'h03: PERIOD command code. Packet is 3 bytes: cmd, slow, fast.
- `clk_i` in 1: system clock. The block uses one clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `host_data_i` in 8: UART rx byte.
- `host_tick_i` in 1: one-cycle strobe; `host_data_i` is valid in that cycle.
- `loc_data_i` in 8: local sequencer byte.
- `loc_valid_i` in 1: local byte valid.
- `loc_ready_o` out 1: local byte accepted when `loc_valid_i & loc_ready_o`.
- `data_o` out 8: byte to the parser (`data_i`).
- `rx_done_tick_o` out 1: one-cycle strobe to the parser (`rx_done_tick_i`).
- `grant_o` out 2: one-hot packet owner. Bit 0 = host, bit 1 = local, 2'b00 = none.
- `busy_o` out 1: a packet is in progress.
- `err_tick_o` out 1: one-cycle pulse when an unknown command byte is dropped.
- `ovf_o` out 1: sticky. Set when a host byte arrives while the FIFO is full.

## Operation
- **Host FIFO.** A write occurs on `host_tick_i` when not full. If the FIFO is full, the byte is dropped and `ovf_o` is set until reset. A write and a pop in the same cycle when full: the pop frees the slot and the write is accepted.
- **Packet length** comes from the head command byte: DATA = 6, FREQ = 5, PERIOD = 3. Any other value is invalid.
- **State machine:** IDLE, SEND, GAP.
- **IDLE, host candidate:** FIFO non-empty.
  - Invalid head: pop it, pulse `err_tick_o`, stay in IDLE.
  - Valid head with count ≥ length: host is eligible.
  - Valid head with count < length: host is not eligible yet.
- **IDLE, local candidate:** `loc_valid_i` asserted.
  - Invalid byte: assert `loc_ready_o` (drop), pulse `err_tick_o`.
  - Valid byte: local is eligible.
- **Grant:** when both are eligible, grant round-robin, toward the source not granted last. After reset, host wins first. On grant: latch the length into `remaining`, set `grant_o`, go to SEND.
  - Invalid-byte drops happen only when no eligible source is being granted that cycle.
- **SEND:** when the owner has a byte, register `data_o`, pulse `rx_done_tick_o`, pop the FIFO or assert `loc_ready_o`, and decrement `remaining`. Then go to GAP, or to IDLE if `GAP_CYCLES` = 0.
  - The host owner never stalls, because the whole packet is already buffered.
  - The local owner may stall (`loc_valid_i` low). The block waits indefinitely; there is no timeout.
- **GAP:** count `GAP_CYCLES`, then go to SEND if `remaining` > 0. Otherwise clear `grant_o` and go to IDLE.
- **Packet contents:** bytes are never inspected after the command byte. Arbitration changes only in IDLE.

## Timing
- Reset values:
  - `data_o` = 0, `rx_done_tick_o` = 0, `grant_o` = 0, `busy_o` = 0, `err_tick_o` = 0, `ovf_o` = 0, `loc_ready_o` = 0.
  - FIFO empty, state IDLE, round-robin pointer at host.
- `loc_ready_o` is combinational from state, owner, and `loc_valid_i`. All other outputs are registered.
- Host latency: the last packet byte is written at cycle n. The grant happens at n+1. The first `rx_done_tick_o` is at n+2.
- Local latency: valid command at cycle k in IDLE gives the grant at k. The first tick is at k+1, and `loc_ready_o` is high in cycle k+1.
- Byte spacing inside a packet is exactly `GAP_CYCLES`+1 cycles when the source does not stall.
- The earliest next grant is the cycle after the final GAP. So packet spacing ≥ `GAP_CYCLES`+2 cycles.
- `busy_o` is high from the grant cycle through the last GAP cycle.
- Reset asserted mid-packet: state, FIFO, and flags clear immediately. The parser may have received a partial packet.

## Configuration
- `CMD_ARB_HOST_PRIORITY_EN` defined: fixed priority; the host always wins when both sources are eligible. The round-robin pointer is removed.
- Not defined: round-robin as described in Operation.

## Test plan
- **Host FREQ packet.** Stimulus: host sends 02,55,55,55,55; no local traffic; `GAP_CYCLES` = 1. Required: 5 ticks 2 cycles apart with the same bytes; first tick 2 cycles after the last write; `grant_o` = 01.
- **Contention.** Stimulus: local holds PERIOD 03,14,05 valid while the host completes DATA 01,55,55,55,55,28 in the same cycle. Required: the host packet is output first, the local packet second, no interleave. A repeated collision grants local first.
- **Local stall.** Stimulus: local sends 01 then drops `loc_valid_i` for 20 cycles mid-packet while host PERIOD bytes arrive. Required: host bytes do not appear until the local packet's 6th byte. After the local packet ends, host PERIOD is output whole.
- **Invalid command.** Stimulus: host sends 7F then 03,14,05. Required: one `err_tick_o` pulse; 7F never appears on `data_o`; the PERIOD packet passes normally.
- **Overflow.** Stimulus: `FIFO_DEPTH` = 8; local owns a stalled packet; host sends 9 bytes. Required: `ovf_o` = 1 after the 9th byte and stays high; the 9th byte is dropped.
- **Reset mid-packet.** Stimulus: `rst_ni` low during the 3rd byte of a host DATA packet. Required: all outputs 0 immediately, FIFO empty; a fresh PERIOD packet after release passes intact.
